// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//   Bundles every non-clock/reset signal of the fetch front end: the jump-unit
//   redirect, the instruction-memory request/response channel and the decode
//   handoff.
//
//   Signals
//     pc_reset_jump     redirect request from jump unit (1-cycle pulse)
//     pc_save_value     redirect target, valid with pc_reset_jump
//     imem_req_valid    fetch request valid
//     imem_req_addr     fetch address
//     imem_req_ready    memory accepts request this cycle
//     imem_rsp_valid    fetch data returned (1-cycle pulse)
//     imem_rsp_data     returned instruction word
//     instr_valid       instruction available to decode
//     instr_data        instruction word
//     instr_pc          address of instr_data
//     instr_ready       decode accepts instruction
//     fetch_misaligned  sticky misaligned-redirect flag
//
//   Modports
//     master  the fetch unit
//     slave   the environment (jump unit, instruction memory, decode)
// ---------------------------------------------------------------------------
interface fetch_unit_if;
  logic        pc_reset_jump;
  logic [31:0] pc_save_value;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fetch_misaligned;

  modport master (
    input  pc_reset_jump,
    input  pc_save_value,
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output instr_valid,
    output instr_data,
    output instr_pc,
    input  instr_ready,
    output fetch_misaligned
  );

  modport slave (
    output pc_reset_jump,
    output pc_save_value,
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  instr_valid,
    input  instr_data,
    input  instr_pc,
    output instr_ready,
    input  fetch_misaligned
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Program-counter owner and instruction-fetch front end. Issues sequential
//   word fetches to instruction memory with at most one request outstanding,
//   buffers the returned word and hands {instr, pc} to decode over a
//   valid/ready handshake. A redirect from the jump unit reloads the PC and
//   squashes every younger in-flight or buffered instruction.
//
//   Parameters
//     RESET_PC   PC loaded on reset; address of the first fetch.
//
//   Ports
//     clk        core clock, rising edge
//     rst_n      asynchronous reset, active low
//     fetch_bus  fetch_unit_if.master: redirect input, imem request/response
//                channel, decode handoff and the fetch_misaligned flag.
//
//   Build option
//     FETCH_MISALIGN_CHECK_EN
//       defined   : a redirect to a non-word-aligned target sets the sticky
//                   fetch_misaligned flag and parks the unit in HALT until an
//                   aligned redirect (or reset) arrives.
//       undefined : the target's low two bits are cleared, fetch_misaligned
//                   is tied low and there is no HALT state.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master fetch_bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
`ifdef FETCH_MISALIGN_CHECK_EN
    S_HALT = 3'd4,
`endif
    S_OUT  = 3'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_next;
  logic        kill;
  logic        kill_next;
  logic        buf_load;
  logic [31:0] buf_data;
  logic [31:0] buf_pc;

  logic        redirect;
  logic [31:0] target;
  logic        req_fire;
  logic        rsp_fire;
  logic        outstanding;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misaligned;
  logic        misaligned_next;
  logic        drain_fire;
`endif

  // Without the alignment check a redirect target is simply forced onto a
  // word boundary; with it the raw value is kept and judged separately.
  function automatic logic [31:0] redirect_target(input logic [31:0] raw);
`ifdef FETCH_MISALIGN_CHECK_EN
    return raw;
`else
    return raw & 32'hFFFF_FFFC;
`endif
  endfunction

  assign redirect = fetch_bus.pc_reset_jump;
  assign target   = redirect_target(fetch_bus.pc_save_value);
  assign req_fire = (state == S_REQ) && fetch_bus.imem_req_ready;
  assign rsp_fire = (state == S_WAIT) && fetch_bus.imem_rsp_valid;

  // A request is still owed a response after this cycle if we are waiting and
  // it has not arrived, or if a request is being accepted right now. Such a
  // response must be discarded when a redirect lands on top of it.
`ifdef FETCH_MISALIGN_CHECK_EN
  assign drain_fire  = (state == S_HALT) && kill && fetch_bus.imem_rsp_valid;
  assign outstanding = ((state == S_WAIT) && !fetch_bus.imem_rsp_valid) ||
                       req_fire ||
                       ((state == S_HALT) && kill && !fetch_bus.imem_rsp_valid);
`else
  assign outstanding = ((state == S_WAIT) && !fetch_bus.imem_rsp_valid) ||
                       req_fire;
`endif

  // Next-state and datapath control; a redirect overrides every other event.
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    fetch_pc_next   = fetch_pc;
    kill_next       = kill;
    buf_load        = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    misaligned_next = misaligned;
`endif

    case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        if (req_fire) begin
          fetch_pc_next = pc;
          pc_next       = pc + 32'd4;
          state_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_fire) begin
          if (kill) begin
            kill_next  = 1'b0;
            state_next = S_REQ;
          end else begin
            buf_load   = 1'b1;
            state_next = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (fetch_bus.instr_ready) state_next = S_REQ;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      S_HALT: begin
        if (drain_fire) kill_next = 1'b0;
      end
`endif
      default: state_next = S_IDLE;
    endcase

    if (redirect) begin
      pc_next    = target;
      buf_load   = 1'b0;
      kill_next  = outstanding;
      state_next = outstanding ? S_WAIT : S_REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
      misaligned_next = |fetch_bus.pc_save_value[1:0];
      if (|fetch_bus.pc_save_value[1:0]) state_next = S_HALT;
`endif
    end
  end

  // Control state: FSM, PC, captured fetch address, kill marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      fetch_pc   <= '0;
      kill       <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misaligned <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      fetch_pc   <= fetch_pc_next;
      kill       <= kill_next;
`ifdef FETCH_MISALIGN_CHECK_EN
      misaligned <= misaligned_next;
`endif
    end
  end

  // Output buffer stage: holds the word presented to decode while it stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data <= '0;
      buf_pc   <= '0;
    end else if (buf_load) begin
      buf_data <= fetch_bus.imem_rsp_data;
      buf_pc   <= fetch_pc;
    end
  end

  assign fetch_bus.imem_req_valid = (state == S_REQ);
  assign fetch_bus.imem_req_addr  = pc;
  // A redirect squashes the buffered word in the same cycle, so a redirect
  // coinciding with instr_ready can never count as a transfer.
  assign fetch_bus.instr_valid    = (state == S_OUT) && !redirect;
  assign fetch_bus.instr_data     = buf_data;
  assign fetch_bus.instr_pc       = buf_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_bus.fetch_misaligned = misaligned;
`else
  assign fetch_bus.fetch_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Directed steps followed by a randomized phase. An instruction-memory model
//   answers requests with programmable latency/readiness, and a program-order
//   reference (next expected PC = previous PC + 4, or the redirect target)
//   checks every instruction handed to decode.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
  logic clk;
  logic rst_n;

  fetch_unit_if fbus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fetch_bus(fbus)
  );

  int checks   = 0;
  int failures = 0;

  int          xfer_cnt = 0;
  logic [31:0] xfer_q[$];

  bit          mem_pend       = 1'b0;
  logic [31:0] mem_addr       = 32'h0;
  int          mem_cnt        = 0;
  int          mem_lat        = 1;
  bit          mem_ready_rand = 1'b0;
  bit          stray_en       = 1'b0;

  logic [31:0] exp_pc = 32'h0;
`ifdef FETCH_MISALIGN_CHECK_EN
  bit          exp_halted = 1'b0;
`endif
  bit          prev_stall    = 1'b0;
  logic [31:0] prev_ipc      = 32'h0;
  logic [31:0] prev_idata    = 32'h0;
  bit          prev_req_wait = 1'b0;
  bit          prev_jump     = 1'b0;
  logic [31:0] prev_req_addr = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_xfer(input string tag);
    int n0;
    int k;
    n0 = xfer_cnt;
    k  = 0;
    while (xfer_cnt == n0 && k < 60) begin
      smp();
      k++;
    end
    chk(tag, 32'(xfer_cnt > n0), 32'd1);
  endtask

  task automatic wait_req(input string tag, output logic [31:0] addr);
    int k;
    k = 0;
    do begin
      smp();
      k++;
    end while (!fbus.imem_req_valid && k < 40);
    chk(tag, 32'(fbus.imem_req_valid), 32'd1);
    addr = fbus.imem_req_addr;
  endtask

  task automatic redirect_pulse(input logic [31:0] t);
    drv();
    fbus.pc_reset_jump = 1'b1;
    fbus.pc_save_value = t;
    drv();
    fbus.pc_reset_jump = 1'b0;
  endtask

  // Instruction memory: records an accepted request at mid-cycle, returns its
  // word mem_cnt cycles later, optionally emits unsolicited responses.
  initial begin
    fbus.imem_req_ready = 1'b1;
    fbus.imem_rsp_valid = 1'b0;
    fbus.imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && fbus.imem_req_valid && fbus.imem_req_ready) begin
        chk("one_outstanding", 32'(mem_pend), 32'd0);
        mem_pend = 1'b1;
        mem_addr = fbus.imem_req_addr;
        mem_cnt  = (mem_lat == 0) ? int'($urandom_range(4, 1)) : mem_lat;
      end
      @(posedge clk);
      #1;
      fbus.imem_rsp_valid = 1'b0;
      if (mem_pend) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          fbus.imem_rsp_valid = 1'b1;
          fbus.imem_rsp_data  = mem_word(mem_addr);
          mem_pend            = 1'b0;
        end
      end else if (stray_en && $urandom_range(7, 0) == 0) begin
        fbus.imem_rsp_valid = 1'b1;
        fbus.imem_rsp_data  = 32'hDEAD_BEEF;
      end
      fbus.imem_req_ready = mem_ready_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // Program-order reference and handshake-rule monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fbus.pc_reset_jump) chk("redirect_squash", 32'(fbus.instr_valid), 32'd0);
      if (prev_stall && !fbus.pc_reset_jump) begin
        chk("stall_valid", 32'(fbus.instr_valid), 32'd1);
        chk("stall_pc", fbus.instr_pc, prev_ipc);
        chk("stall_data", fbus.instr_data, prev_idata);
      end
      if (prev_req_wait && !prev_jump) begin
        chk("req_hold_valid", 32'(fbus.imem_req_valid), 32'd1);
        chk("req_hold_addr", fbus.imem_req_addr, prev_req_addr);
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("misaligned_flag", 32'(fbus.fetch_misaligned), 32'(exp_halted));
      if (exp_halted) begin
        chk("halt_no_req", 32'(fbus.imem_req_valid), 32'd0);
        chk("halt_no_instr", 32'(fbus.instr_valid), 32'd0);
      end
`else
      chk("misaligned_tied", 32'(fbus.fetch_misaligned), 32'd0);
`endif
      if (fbus.instr_valid && fbus.instr_ready) begin
        chk("xfer_pc", fbus.instr_pc, exp_pc);
        chk("xfer_data", fbus.instr_data, mem_word(fbus.instr_pc));
        xfer_q.push_back(fbus.instr_pc);
        xfer_cnt++;
        exp_pc = fbus.instr_pc + 32'd4;
      end
      if (fbus.pc_reset_jump) begin
`ifdef FETCH_MISALIGN_CHECK_EN
        if (fbus.pc_save_value[1:0] != 2'b00) begin
          exp_halted = 1'b1;
        end else begin
          exp_halted = 1'b0;
          exp_pc     = fbus.pc_save_value;
        end
`else
        exp_pc = {fbus.pc_save_value[31:2], 2'b00};
`endif
      end
      prev_stall    = fbus.instr_valid && !fbus.instr_ready && !fbus.pc_reset_jump;
      prev_ipc      = fbus.instr_pc;
      prev_idata    = fbus.instr_data;
      prev_req_wait = fbus.imem_req_valid && !fbus.imem_req_ready;
      prev_req_addr = fbus.imem_req_addr;
      prev_jump     = fbus.pc_reset_jump;
    end
  end

  initial begin
    logic [31:0] addr;
    logic [31:0] r;
    int          n_rand;
    int          k;

    rst_n              = 1'b0;
    fbus.pc_reset_jump = 1'b0;
    fbus.pc_save_value = 32'h0;
    fbus.instr_ready   = 1'b0;

    // Reset state
    smp();
    smp();
    chk("rst_req_valid", 32'(fbus.imem_req_valid), 32'd0);
    chk("rst_req_addr", fbus.imem_req_addr, 32'h0);
    chk("rst_instr_valid", 32'(fbus.instr_valid), 32'd0);
    chk("rst_instr_data", fbus.instr_data, 32'h0);
    chk("rst_instr_pc", fbus.instr_pc, 32'h0);
    chk("rst_misaligned", 32'(fbus.fetch_misaligned), 32'd0);

    fbus.instr_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_no_req", 32'(fbus.imem_req_valid), 32'd0);
    smp();
    chk("first_req_valid", 32'(fbus.imem_req_valid), 32'd1);
    chk("first_req_addr", fbus.imem_req_addr, 32'h0);

    // Sequential fetch, 1-cycle memory
    wait_xfer("seq_xfer0");
    wait_xfer("seq_xfer1");
    wait_xfer("seq_xfer2");
    chk("seq_pc0", xfer_q[0], 32'h0);
    chk("seq_pc1", xfer_q[1], 32'h4);
    chk("seq_pc2", xfer_q[2], 32'h8);

    // Restart at 0 and stall decode while pc 0x4 is presented
    redirect_pulse(32'h0);
    wait_xfer("restart_xfer");
    chk("restart_pc", xfer_q[$], 32'h0);
    drv();
    fbus.instr_ready = 1'b0;
    k = 0;
    do begin
      smp();
      k++;
    end while (!fbus.instr_valid && k < 20);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) smp();
      chk("stall_hold_valid", 32'(fbus.instr_valid), 32'd1);
      chk("stall_hold_pc", fbus.instr_pc, 32'h4);
      chk("stall_hold_data", fbus.instr_data, mem_word(32'h4));
      chk("stall_no_req", 32'(fbus.imem_req_valid), 32'd0);
    end
    mem_lat = 3;
    drv();
    fbus.instr_ready = 1'b1;
    smp();
    chk("unstall_xfer_pc", xfer_q[$], 32'h4);
    smp();
    chk("next_req_valid", 32'(fbus.imem_req_valid), 32'd1);
    chk("next_req_addr", fbus.imem_req_addr, 32'h8);

    // Redirect while fetch of 0x8 is outstanding
    redirect_pulse(32'h100);
    wait_req("kill_req", addr);
    chk("kill_req_addr", addr, 32'h100);
    mem_lat = 1;
    wait_xfer("kill_xfer");
    chk("kill_xfer_pc", xfer_q[$], 32'h100);

    // Redirect coinciding with a presented instruction and instr_ready
    k = 0;
    do begin
      smp();
      k++;
    end while (!fbus.imem_rsp_valid && k < 20);
    chk("pre_squash_rsp", 32'(fbus.imem_rsp_valid), 32'd1);
    k = xfer_cnt;
    drv();
    fbus.pc_reset_jump = 1'b1;
    fbus.pc_save_value = 32'h40;
    smp();
    chk("squash_valid", 32'(fbus.instr_valid), 32'd0);
    chk("squash_no_xfer", 32'(xfer_cnt), 32'(k));
    drv();
    fbus.pc_reset_jump = 1'b0;
    wait_xfer("squash_xfer");
    chk("squash_xfer_pc", xfer_q[$], 32'h40);

    // PC wrap-around
    redirect_pulse(32'hFFFF_FFFC);
    wait_xfer("wrap_xfer0");
    chk("wrap_pc0", xfer_q[$], 32'hFFFF_FFFC);
    wait_xfer("wrap_xfer1");
    chk("wrap_pc1", xfer_q[$], 32'h0);

    // Misaligned redirect target
    redirect_pulse(32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
    smp();
    chk("mis_flag_set", 32'(fbus.fetch_misaligned), 32'd1);
    for (int i = 0; i < 8; i++) begin
      smp();
      chk("mis_halt_req", 32'(fbus.imem_req_valid), 32'd0);
      chk("mis_halt_instr", 32'(fbus.instr_valid), 32'd0);
    end
    redirect_pulse(32'h200);
    smp();
    chk("mis_flag_clear", 32'(fbus.fetch_misaligned), 32'd0);
    wait_req("mis_exit_req", addr);
    chk("mis_exit_addr", addr, 32'h200);
    wait_xfer("mis_exit_xfer");
    chk("mis_exit_pc", xfer_q[$], 32'h200);
`else
    wait_req("mis_req", addr);
    chk("mis_req_addr", addr, 32'h100);
    chk("mis_flag_zero", 32'(fbus.fetch_misaligned), 32'd0);
    wait_xfer("mis_xfer");
    chk("mis_xfer_pc", xfer_q[$], 32'h100);
`endif

    // Randomized traffic: random memory readiness/latency, stray responses,
    // random decode back-pressure and random redirects
    mem_ready_rand = 1'b1;
    mem_lat        = 0;
    stray_en       = 1'b1;
    n_rand         = xfer_cnt;
    for (int c = 0; c < 3000; c++) begin
      drv();
      fbus.instr_ready = 1'($urandom_range(1, 0));
      if ($urandom_range(15, 0) == 0) begin
        r = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
        if ($urandom_range(7, 0) != 0) r[1:0] = 2'b00;
`endif
        fbus.pc_reset_jump = 1'b1;
        fbus.pc_save_value = r;
      end else begin
        fbus.pc_reset_jump = 1'b0;
      end
    end
    drv();
    fbus.pc_reset_jump = 1'b0;
    fbus.instr_ready   = 1'b1;
    mem_ready_rand     = 1'b0;
    mem_lat            = 1;
    stray_en           = 1'b0;
    chk("rand_progress", 32'(xfer_cnt - n_rand > 100), 32'd1);

    redirect_pulse(32'h1000);
    wait_xfer("final_xfer");
    chk("final_pc", xfer_q[$], 32'h1000);

    // Asynchronous reset assertion mid-cycle
    drv();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req_valid", 32'(fbus.imem_req_valid), 32'd0);
    chk("arst_req_addr", fbus.imem_req_addr, 32'h0);
    chk("arst_instr_valid", 32'(fbus.instr_valid), 32'd0);
    chk("arst_instr_data", fbus.instr_data, 32'h0);
    chk("arst_instr_pc", fbus.instr_pc, 32'h0);
    chk("arst_misaligned", 32'(fbus.fetch_misaligned), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
